// File: rtl/pwm_ramp_controller.sv
// PWM duty sequencer: debounced buttons and host loads set a target duty,
// and the applied duty slews toward it once per RAMP_DIV PWM periods.
module pwm_ramp_controller #(
    parameter int DUTY_W    = 4,
    parameter int PERIOD    = 10,
    parameter int DUTY_MAX  = 10,
    parameter int DUTY_INIT = 5,
    parameter int RAMP_DIV  = 4,
    parameter int DEB_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              load_valid,
    input  logic [DUTY_W-1:0] load_duty,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_now,
    output logic [DUTY_W-1:0] duty_target,
    output logic              busy
);
    localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int RCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DCNT_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_DIV - 1);
    localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DINIT     = DUTY_W'(DUTY_INIT);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RAMP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [1:0]        inc_s_q, inc_s_d;
    logic [1:0]        dec_s_q, dec_s_d;
    logic              tick, inc_p, dec_p, step;
    logic [DUTY_W-1:0] duty_step;

    // Bit 0 is the newest sample; a press is a 0->1 seen across two ticks.
    always_comb begin
        tick    = (dcnt_q == DCNT_LAST);
        dcnt_d  = tick ? '0 : dcnt_q + 1'b1;
        inc_s_d = inc_s_q;
        dec_s_d = dec_s_q;
        if (tick) begin
            inc_s_d = {inc_s_q[0], inc_btn};
            dec_s_d = {dec_s_q[0], dec_btn};
        end
        inc_p = tick & inc_s_q[0] & ~inc_s_q[1];
        dec_p = tick & dec_s_q[0] & ~dec_s_q[1];
    end

    always_comb begin
        tgt_d = tgt_q;
        if (load_valid) begin
            tgt_d = (load_duty > DMAX) ? DMAX : load_duty;
        end else if (inc_p & ~dec_p) begin
            tgt_d = (tgt_q >= DMAX) ? DMAX : tgt_q + 1'b1;
        end else if (dec_p & ~inc_p) begin
            tgt_d = (tgt_q == '0) ? '0 : tgt_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        rcnt_d    = rcnt_q;
        duty_d    = duty_q;
        step      = (pcnt_q == PCNT_LAST);
        duty_step = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
        if (!ena) begin
            state_d = ST_OFF;
            pcnt_d  = '0;
            rcnt_d  = '0;
            duty_d  = '0;
        end else begin
            pcnt_d = (state_q == ST_OFF || step) ? '0 : pcnt_q + 1'b1;
            case (state_q)
                ST_OFF: begin
                    duty_d  = '0;
                    rcnt_d  = '0;
                    state_d = (tgt_q == '0) ? ST_IDLE : ST_RAMP;
                end
                ST_IDLE: begin
                    if (tgt_q != duty_q) begin
                        state_d = ST_RAMP;
                        rcnt_d  = '0;
                    end
                end
                ST_RAMP: begin
                    if (tgt_q == duty_q) begin
                        state_d = ST_IDLE;
                    end else if (step) begin
                        if (rcnt_q == RCNT_LAST) begin
                            rcnt_d = '0;
                            duty_d = duty_step;
                            if (duty_step == tgt_q) state_d = ST_IDLE;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            pcnt_q  <= '0;
            rcnt_q  <= '0;
            duty_q  <= '0;
            tgt_q   <= DINIT;
            dcnt_q  <= '0;
            inc_s_q <= '0;
            dec_s_q <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            rcnt_q  <= rcnt_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            dcnt_q  <= dcnt_d;
            inc_s_q <= inc_s_d;
            dec_s_q <= dec_s_d;
        end
    end

    assign pwm_out      = (state_q != ST_OFF) && (32'(pcnt_q) < 32'(duty_q));
    assign period_start = (pcnt_q == '0);
    assign duty_now     = duty_q;
    assign duty_target  = tgt_q;
    assign busy         = (state_q == ST_RAMP);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Scoreboard bench for pwm_ramp_controller: directed scenarios plus random
// stimulus, each cycle checked against a behavioural model.
module tb_pwm_ramp_controller;
    localparam int DUTY_W    = 4;
    localparam int PERIOD    = 10;
    localparam int DUTY_MAX  = 10;
    localparam int DUTY_INIT = 5;
    localparam int RAMP_DIV  = 2;
    localparam int DEB_DIV   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              inc_btn = 1'b0;
    logic              dec_btn = 1'b0;
    logic              load_valid = 1'b0;
    logic [DUTY_W-1:0] load_duty = '0;
    logic              pwm_out, period_start, busy;
    logic [DUTY_W-1:0] duty_now, duty_target;

    pwm_ramp_controller #(
        .DUTY_W(DUTY_W), .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX),
        .DUTY_INIT(DUTY_INIT), .RAMP_DIV(RAMP_DIV), .DEB_DIV(DEB_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .inc_btn(inc_btn), .dec_btn(dec_btn),
        .load_valid(load_valid), .load_duty(load_duty),
        .pwm_out(pwm_out), .period_start(period_start),
        .duty_now(duty_now), .duty_target(duty_target), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pwm;
        logic       ps;
        logic [3:0] duty;
        logic [3:0] tgt;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model: time since run start gives the period position,
    // elapsed cycles since reset give the debounce sampling phase.
    int       m_clk, m_runc, m_duty, m_tgt, m_pts;
    bit       m_on, m_ramp;
    bit [1:0] m_ih, m_dh;

    bit b_rst = 1'b0, b_ena = 1'b0, b_inc = 1'b0, b_dec = 1'b0;

    task automatic model_reset();
        m_clk = 0; m_runc = 0; m_duty = 0; m_tgt = DUTY_INIT; m_pts = 0;
        m_on = 1'b0; m_ramp = 1'b0; m_ih = '0; m_dh = '0;
    endtask

    task automatic model_edge(input bit r, input bit e, input bit ib,
                              input bit db, input bit lv, input int ld);
        bit sample, ip, dp;
        int nt, pos;
        if (!r) begin
            model_reset();
            return;
        end
        sample = ((m_clk % DEB_DIV) == DEB_DIV - 1);
        ip = sample && m_ih[0] && !m_ih[1];
        dp = sample && m_dh[0] && !m_dh[1];
        nt = m_tgt;
        if (lv) nt = (ld > DUTY_MAX) ? DUTY_MAX : ld;
        else if (ip && !dp) nt = (m_tgt + 1 > DUTY_MAX) ? DUTY_MAX : m_tgt + 1;
        else if (dp && !ip) nt = (m_tgt == 0) ? 0 : m_tgt - 1;
        pos = m_runc % PERIOD;
        if (!e) begin
            m_on = 1'b0; m_ramp = 1'b0; m_duty = 0; m_runc = 0;
        end else if (!m_on) begin
            m_on = 1'b1; m_ramp = (m_tgt != 0); m_duty = 0; m_pts = 0;
        end else begin
            m_runc++;
            if (!m_ramp) begin
                if (m_tgt != m_duty) begin m_ramp = 1'b1; m_pts = 0; end
            end else if (m_tgt == m_duty) begin
                m_ramp = 1'b0;
            end else if (pos == PERIOD - 1) begin
                m_pts++;
                if (m_pts == RAMP_DIV) begin
                    m_pts = 0;
                    m_duty = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                    if (m_duty == m_tgt) m_ramp = 1'b0;
                end
            end
        end
        m_tgt = nt;
        if (sample) begin
            m_ih = {m_ih[0], ib};
            m_dh = {m_dh[0], db};
        end
        m_clk++;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        int pos;
        pos    = m_runc % PERIOD;
        o.pwm  = m_on && (pos < m_duty);
        o.ps   = (pos == 0);
        o.duty = 4'(m_duty);
        o.tgt  = 4'(m_tgt);
        o.busy = m_ramp;
        return o;
    endfunction

    task automatic drive(input bit lv, input int ld);
        @(negedge clk);
        rst_n = b_rst; ena = b_ena; inc_btn = b_inc; dec_btn = b_dec;
        load_valid = lv; load_duty = DUTY_W'(ld);
        model_edge(b_rst, b_ena, b_inc, b_dec, lv, ld);
        exp_q.push_back(model_obs());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pwm_out, period_start, duty_now, duty_target, busy};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: got pwm=%b ps=%b duty=%0d tgt=%0d busy=%b, expected pwm=%b ps=%b duty=%0d tgt=%0d busy=%b",
                             $time, a.pwm, a.ps, a.duty, a.tgt, a.busy,
                             e.pwm, e.ps, e.duty, e.tgt, e.busy);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        model_reset();
        b_rst = 1'b0;
        run(3);
        drive(1'b0, 0);
        settle();
        chk("reset_duty", int'(duty_now), 0);
        chk("reset_tgt", int'(duty_target), DUTY_INIT);
        chk("reset_pwm", int'(pwm_out), 0);

        b_rst = 1'b1; b_ena = 1'b1;
        run(120);
        drive(1'b0, 0);
        settle();
        chk("softstart_duty", int'(duty_now), 5);
        chk("softstart_busy", int'(busy), 0);

        b_inc = 1'b1; run(20); b_inc = 1'b0;
        run(40);
        drive(1'b0, 0);
        settle();
        chk("inc_tgt", int'(duty_target), 6);
        chk("inc_duty", int'(duty_now), 6);

        while ((m_clk % DEB_DIV) == DEB_DIV - 1) run(1);
        b_inc = 1'b1; run(1); b_inc = 1'b0;
        run(10);
        drive(1'b0, 0);
        settle();
        chk("glitch_tgt", int'(duty_target), 6);

        drive(1'b1, 15);
        settle();
        chk("clamp_tgt", int'(duty_target), DUTY_MAX);
        run(100);
        for (int i = 0; i < PERIOD; i++) begin
            drive(1'b0, 0);
            settle();
            chk("full_on_pwm", int'(pwm_out), 1);
        end

        drive(1'b1, 0);
        run(230);
        drive(1'b0, 0);
        settle();
        chk("down_duty", int'(duty_now), 0);
        chk("down_pwm", int'(pwm_out), 0);

        drive(1'b1, 2);
        run(70);
        drive(1'b1, 8);
        guard = 0;
        while (m_duty != 4 && guard < 200) begin
            run(1);
            guard++;
        end
        drive(1'b0, 0);
        settle();
        chk("reach_duty4", int'(duty_now), 4);
        drive(1'b1, 1);
        run(100);
        drive(1'b0, 0);
        settle();
        chk("reverse_duty", int'(duty_now), 1);
        chk("reverse_busy", int'(busy), 0);

        b_inc = 1'b1; b_dec = 1'b1; run(6);
        b_inc = 1'b0; b_dec = 1'b0; run(10);
        drive(1'b0, 0);
        settle();
        chk("incdec_tgt", int'(duty_target), 1);
        drive(1'b1, 0);
        run(60);
        b_dec = 1'b1; run(6); b_dec = 1'b0; run(10);
        drive(1'b0, 0);
        settle();
        chk("dec_floor_tgt", int'(duty_target), 0);

        drive(1'b1, 9);
        run(50);
        drive(1'b0, 0);
        settle();
        chk("midramp_busy", int'(busy), 1);
        b_ena = 1'b0;
        drive(1'b0, 0);
        settle();
        chk("enaoff_pwm", int'(pwm_out), 0);
        chk("enaoff_duty", int'(duty_now), 0);
        chk("enaoff_tgt", int'(duty_target), 9);
        run(5);
        b_ena = 1'b1;
        run(30);
        b_rst = 1'b0;
        drive(1'b0, 0);
        settle();
        chk("rst_mid_duty", int'(duty_now), 0);
        chk("rst_mid_tgt", int'(duty_target), DUTY_INIT);
        chk("rst_mid_busy", int'(busy), 0);
        b_rst = 1'b1;
        run(20);

        for (int i = 0; i < 3000; i++) begin
            b_rst = ($urandom_range(299) != 0);
            if ($urandom_range(199) == 0) b_ena = ~b_ena;
            if (!b_ena && $urandom_range(9) == 0) b_ena = 1'b1;
            if ($urandom_range(11) == 0) b_inc = ~b_inc;
            if ($urandom_range(11) == 0) b_dec = ~b_dec;
            drive($urandom_range(49) == 0, int'($urandom_range(15)));
        end
        b_rst = 1'b1; b_inc = 1'b0; b_dec = 1'b0;
        run(3);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
